rf_wb_arbiter: RTL and testbench

//  Owns the single register-file write port and the debug read-select port.
//  - Shares the write port between NREQ writeback requesters (ALU, load, CSR/debug) using round-robin.
//  - Runs a sequenced snapshot dump of all 32 registers over the debug read port.
//  - Sits between the pipeline writeback stage and the RF. Drives RFWr/A3/WD and reg_sel, and samples reg_data.

---
 rtl/rf_ctrl_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 23 ++
 rtl/rf_wb_arbiter.sv | 109 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared encodings for the register-file writeback/debug controller.
package rf_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DUMP  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int REG_NUM = 32;
    localparam int REG_AW  = 5;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: the first requester after ptr wins.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);
    always_comb begin
        gnt = '0;
        if (en) begin
            // Scan cyclically starting just after the last winner.
            for (int k = NREQ; k >= 1; k--) begin
                if (req[(int'(ptr) + k) % NREQ]) begin
                    gnt = '0;
                    gnt[(int'(ptr) + k) % NREQ] = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Owns the RF write port (round-robin over writeback requesters) and the
// debug read port (sequenced 32-register snapshot dump).
module rf_wb_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  req_ready,
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    output logic [AW-1:0]    rf_rsel,
    input  logic [DW-1:0]    rf_rdata,
    input  logic             dump_start,
    output logic             dump_busy,
    output logic             dump_valid,
    output logic [AW-1:0]    dump_addr,
    output logic [DW-1:0]    dump_data,
    output logic             dump_done
);
    localparam int PW = $clog2(NREQ);

    state_t            state, state_nx;
    logic [REG_AW-1:0] idx;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gnt_idx;
    logic [NREQ-1:0]   gnt;
    logic              arb_en;
    logic              xfer;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_data;

    // A dump request outranks any pending write in the same cycle.
    assign arb_en = rst && (state == ST_IDLE) && !dump_start;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign xfer      = |(gnt & req_valid);
    assign rf_rsel   = AW'(idx);
    assign dump_busy = (state != ST_IDLE);

    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx  = PW'(i);
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (dump_start) state_nx = ST_DUMP;
            ST_DUMP:  if (idx == REG_AW'(REG_NUM - 1)) state_nx = ST_DRAIN;
            ST_DRAIN: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= PW'(NREQ - 1);
            idx        <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_DUMP)
                idx <= (idx == REG_AW'(REG_NUM - 1)) ? '0 : idx + 1'b1;
            // r0 is hardwired zero, so its writes are consumed but dropped.
            rf_we <= xfer && (sel_addr != '0);
            if (xfer) begin
                rr_ptr   <= gnt_idx;
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
            dump_valid <= (state == ST_DUMP);
            dump_done  <= (state == ST_DRAIN);
            if (state == ST_DUMP) begin
                dump_addr <= AW'(idx);
                dump_data <= (idx == '0) ? '0 : rf_rdata;
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized + directed bench for rf_wb_arbiter with an RF model and a
// queue-based scoreboard fed by a transaction-level reference model.
module tb_rf_wb_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic [AW-1:0]     rf_rsel;
    logic [DW-1:0]     rf_rdata;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic [AW-1:0]     dump_addr;
    logic [DW-1:0]     dump_data;
    logic              dump_done;

    rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_rsel(rf_rsel), .rf_rdata(rf_rdata),
        .dump_start(dump_start), .dump_busy(dump_busy),
        .dump_valid(dump_valid), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    // Register file: commits on negedge, reads combinationally, r0 reads zero.
    logic [DW-1:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(negedge clk) if (rf_we === 1'b1 && rf_waddr != '0) rf[rf_waddr] <= rf_wdata;
    assign rf_rdata = (rf_rsel == '0) ? '0 : rf[rf_rsel];

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    beat_t         wq[$];
    beat_t         dq[$];
    int            done_cnt = 0;
    int            checks = 0;
    int            failures = 0;
    int            last = NREQ - 1;
    int            busy_left = 0;
    bit            pend_rst = 1'b1;
    logic [DW-1:0] mregs [32];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=unexpected expected=none at %0t", nm, $time);
    endtask

    // One clock of stimulus plus the reference model's view of that cycle.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                        input logic [NREQ*DW-1:0] d, input logic start, input logic r);
        logic [NREQ-1:0] exp_ready;
        int exp_rsel;
        bit exp_busy;
        bit was_rst;
        @(posedge clk);
        #1;
        was_rst = pend_rst;
        if (pend_rst) begin
            last = NREQ - 1;
            busy_left = 0;
            dq.delete();
            done_cnt = 0;
            pend_rst = 1'b0;
        end
        req_valid = v; req_addr = a; req_data = d; dump_start = start; rst = r;
        #1;
        exp_ready = '0;
        exp_busy  = (busy_left > 0);
        exp_rsel  = (busy_left >= 2) ? 33 - busy_left : 0;
        if (!r) begin
            pend_rst = 1'b1;
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (start) begin
            for (int i = 0; i < 32; i++) dq.push_back('{a: AW'(i), d: (i == 0) ? '0 : mregs[i]});
            busy_left = 33;
            done_cnt++;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (last + k) % NREQ;
                if (v[i]) begin
                    exp_ready = '0;
                    exp_ready[i] = 1'b1;
                    last = i;
                    if (a[i*AW +: AW] != '0) begin
                        mregs[a[i*AW +: AW]] = d[i*DW +: DW];
                        wq.push_back('{a: a[i*AW +: AW], d: d[i*DW +: DW]});
                    end
                    break;
                end
            end
        end
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("dump_busy", 64'(dump_busy), 64'(exp_busy));
        check("rf_rsel", 64'(rf_rsel), 64'(exp_rsel));
        if (was_rst) begin
            check("rst_rf_we", 64'(rf_we), 64'd0);
            check("rst_dump_valid", 64'(dump_valid), 64'd0);
            check("rst_dump_done", 64'(dump_done), 64'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, 1'b1);
    endtask

    // Monitor: consumes expected transactions whenever the DUT presents one.
    bit            prev_valid = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (wq.size() == 0) flag("wr_unexpected");
            else begin
                beat_t e;
                e = wq.pop_front();
                check("wr_addr", 64'(rf_waddr), 64'(e.a));
                check("wr_data", 64'(rf_wdata), 64'(e.d));
            end
        end
        if (dump_valid === 1'b1) begin
            if (dq.size() == 0) flag("dump_unexpected");
            else begin
                beat_t e;
                e = dq.pop_front();
                check("dump_addr", 64'(dump_addr), 64'(e.a));
                check("dump_data", 64'(dump_data), 64'(e.d));
            end
            if (dump_addr != '0)
                check("dump_consec", 64'({prev_valid, prev_addr}), 64'({1'b1, dump_addr - 1'b1}));
        end
        if (dump_done === 1'b1) begin
            check("done_timing", 64'({prev_valid, prev_addr}), 64'({1'b1, 5'd31}));
            if (done_cnt == 0) flag("done_unexpected");
            else done_cnt--;
        end
        prev_valid = (dump_valid === 1'b1);
        prev_addr  = dump_addr;
    end

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        rst = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; dump_start = 1'b0;
        step('0, '0, '0, 1'b0, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0);
        idle(1);
        // Single write from requester 0.
        step(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEADBEEF}, 1'b0, 1'b1);
        idle(1);
        // All three contending for four cycles.
        for (int i = 0; i < 4; i++)
            step(3'b111, {5'd3, 5'd2, 5'd1}, {$urandom, $urandom, $urandom}, 1'b0, 1'b1);
        idle(1);
        // Write to r0 is consumed without an RF write.
        step(3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'h1234, 32'd0}, 1'b0, 1'b1);
        idle(1);
        // Preload r7, then dump while requester 0 waits.
        step(3'b001, {5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'h77}, 1'b0, 1'b1);
        idle(1);
        step(3'b001, {5'd0, 5'd0, 5'd3}, {32'd0, 32'd0, 32'h33}, 1'b1, 1'b1);
        for (int i = 0; i < 35; i++)
            step(3'b001, {5'd0, 5'd0, 5'd3}, {32'd0, 32'd0, 32'h33}, 1'b0, 1'b1);
        idle(2);
        // Write granted the cycle before dump_start is in the snapshot.
        step(3'b001, {5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, 32'hAA}, 1'b0, 1'b1);
        step('0, '0, '0, 1'b1, 1'b1);
        idle(36);
        // Reset in the middle of a dump.
        step('0, '0, '0, 1'b1, 1'b1);
        idle(10);
        step('0, '0, '0, 1'b0, 1'b0);
        step(3'b111, {5'd3, 5'd2, 5'd1}, {32'd3, 32'd2, 32'd1}, 1'b0, 1'b0);
        step(3'b111, {5'd3, 5'd2, 5'd1}, {32'd3, 32'd2, 32'd1}, 1'b0, 1'b1);
        idle(2);
        // Random traffic with occasional dumps.
        for (int n = 0; n < 600; n++)
            step(3'($urandom), 15'($urandom), {$urandom, $urandom, $urandom},
                 ($urandom_range(0, 49) == 0), 1'b1);
        idle(40);
        check("wq_empty", 64'(wq.size()), 64'd0);
        check("dq_empty", 64'(dq.size()), 64'd0);
        check("done_empty", 64'(done_cnt), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
